tick_processor: RTL and testbench

Parametrised successor to the team's 16-bit demo processor. Fetches 16-bit instructions from an external asynchronous ROM and executes one instruction per prescaler tick. Adds synchronous reset, configurable data width, program depth and tick rate, a full logic/shift ALU, Z and C flags, conditional branches and optional HALT. Sits between the instruction ROM and the board output register/display driver.

---
 rtl/tick_processor.sv | 138 +++++++++++++
 tb/tb_tick_processor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_processor.sv
// Tick-paced 16-bit-instruction processor: eight DATA_W registers, Z/C flags, branches, OUT port.
// Define TICK_PROCESSOR_HALT_EN to make opcode E a sticky HALT; otherwise E is a NOP and halted stays 0.
module tick_processor #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              halted
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
`ifdef TICK_PROCESSOR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
    OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_SHL  = 4'h7,
    OP_JMP  = 4'h8, OP_BZ   = 4'h9, OP_BNZ  = 4'hA, OP_BC   = 4'hB,
    OP_NOPC = 4'hC, OP_NOPD = 4'hD, OP_HALT = 4'hE, OP_OUT  = 4'hF
  } op_e;

  // Returns {carry/borrow, value}; logic ops clear the carry bit naturally.
  function automatic logic [DATA_W:0] alu(input op_e opc, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    case (opc)
      OP_ADD:  alu = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu = {1'b0, a} - {1'b0, b};
      OP_AND:  alu = {1'b0, a & b};
      OP_OR:   alu = {1'b0, a | b};
      OP_XOR:  alu = {1'b0, a ^ b};
      OP_SHL:  alu = {a, 1'b0};
      default: alu = {1'b0, a};
    endcase
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  op_e               op;
  logic [2:0]        ra, rb;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] ra_val, rb_val;
  logic [DATA_W:0]   alu_out;
  logic              tick;

  assign op     = op_e'(instruction[15:12]);
  assign ra     = instruction[11:9];
  assign rb     = instruction[8:6];
  assign imm    = instruction[7:0];
  assign target = instruction[ADDR_W-1:0];
  assign ra_val = regs_q[ra];
  assign rb_val = regs_q[rb];

  always_comb begin
    regs_d      = regs_q;
    z_d         = z_q;
    c_d         = c_q;
    address_d   = address_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    tick        = (cnt_q == CNT_MAX);
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    alu_out     = alu(op, ra_val, rb_val);

    if (tick && !halted_q) begin
      address_d = address_q + ADDR_W'(1);
      case (op)
        OP_LDI: regs_d[ra] = DATA_W'(imm);
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
          regs_d[ra] = alu_out[DATA_W-1:0];
          z_d        = (alu_out[DATA_W-1:0] == '0);
          c_d        = alu_out[DATA_W];
        end
        OP_JMP: address_d = target;
        OP_BZ:  if (z_q)  address_d = target;
        OP_BNZ: if (!z_q) address_d = target;
        OP_BC:  if (c_q)  address_d = target;
        OP_HALT: begin
          if (HALT_EN) begin
            halted_d  = 1'b1;
            address_d = address_q;
          end
        end
        OP_OUT: begin
          result_d    = ra_val;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      address_q   <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      address_q   <= address_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      z_q         <= z_d;
      c_q         <= c_d;
      regs_q      <= regs_d;
    end
  end

  assign address   = address_q;
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_tick_processor.sv
// Bench for tick_processor: ALU vector table, hand sequences and a randomized program run against a tick-level model.
module tb_tick_processor;

`ifdef TICK_PROCESSOR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // DUT 8: DATA_W=8, ADDR_W=4, TICK_DIV=1 (ALU table)
  logic        rst8;
  logic [15:0] rom8 [16];
  logic [15:0] ins8;
  logic [3:0]  addr8;
  logic [7:0]  res8;
  logic        ov8, hlt8;
  assign ins8 = rom8[addr8];
  tick_processor #(.DATA_W(8), .ADDR_W(4), .TICK_DIV(1)) dut8 (
    .clk(clk), .rst(rst8), .instruction(ins8), .address(addr8),
    .result(res8), .out_valid(ov8), .halted(hlt8));

  // DUT 16: DATA_W=16, ADDR_W=4, TICK_DIV=1 (sequences and random)
  logic        rst16;
  logic [15:0] rom16 [16];
  logic [15:0] ins16;
  logic [3:0]  addr16;
  logic [15:0] res16;
  logic        ov16, hlt16;
  assign ins16 = rom16[addr16];
  tick_processor #(.DATA_W(16), .ADDR_W(4), .TICK_DIV(1)) dut16 (
    .clk(clk), .rst(rst16), .instruction(ins16), .address(addr16),
    .result(res16), .out_valid(ov16), .halted(hlt16));

  // DUT P: DATA_W=16, ADDR_W=2, TICK_DIV=4 (prescaler, wrap, loop)
  logic        rstp;
  logic [15:0] romp [4];
  logic [15:0] insp;
  logic [1:0]  addrp;
  logic [15:0] resp;
  logic        ovp, hltp;
  assign insp = romp[addrp];
  tick_processor #(.DATA_W(16), .ADDR_W(2), .TICK_DIV(4)) dutp (
    .clk(clk), .rst(rstp), .instruction(insp), .address(addrp),
    .result(resp), .out_valid(ovp), .halted(hltp));

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tick-level reference model for the 16-bit, 16-word core
  localparam int MW = 16;
  localparam int MA = 16;
  longint m_regs [8];
  bit     m_z, m_c, m_ov, m_halted;
  int     m_pc;
  longint m_result;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_z = 0; m_c = 0; m_ov = 0; m_halted = 0; m_pc = 0; m_result = 0;
  endtask

  task automatic model_step(input logic [15:0] ins);
    longint mask, a, b, v;
    int op, ra, rb, npc;
    bit wr;
    mask = (longint'(1) << MW) - 1;
    op = int'(ins[15:12]);
    ra = int'(ins[11:9]);
    rb = int'(ins[8:6]);
    a  = m_regs[ra];
    b  = m_regs[rb];
    v  = 0;
    wr = 0;
    m_ov = 0;
    if (m_halted) return;
    npc = (m_pc + 1) % MA;
    case (op)
      1:  m_regs[ra] = longint'(ins[7:0]) & mask;
      2:  begin v = a + b; m_c = (v > mask); v = v & mask; wr = 1; end
      3:  begin m_c = (a < b); v = (a - b) & mask; wr = 1; end
      4:  begin v = a & b; m_c = 0; wr = 1; end
      5:  begin v = a | b; m_c = 0; wr = 1; end
      6:  begin v = a ^ b; m_c = 0; wr = 1; end
      7:  begin m_c = ((a >> (MW - 1)) & 1) == 1; v = (a << 1) & mask; wr = 1; end
      8:  npc = int'(ins) % MA;
      9:  if (m_z)  npc = int'(ins) % MA;
      10: if (!m_z) npc = int'(ins) % MA;
      11: if (m_c)  npc = int'(ins) % MA;
      14: if (HALT_EN) begin m_halted = 1; npc = m_pc; end
      15: begin m_result = a; m_ov = 1; end
      default: ;
    endcase
    if (wr) begin
      m_regs[ra] = v;
      m_z = (v == 0);
    end
    m_pc = npc;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    bit         z;
    bit         c;
  } vec_t;
  vec_t tbl [18];

  initial begin
    vec_t v;
    int exp_addr;
    logic [15:0] w;

    tbl[0]  = '{4'h2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    tbl[1]  = '{4'h2, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    tbl[2]  = '{4'h2, 8'h80, 8'h90, 8'h10, 1'b0, 1'b1};
    tbl[3]  = '{4'h3, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    tbl[4]  = '{4'h3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{4'h3, 8'h09, 8'h04, 8'h05, 1'b0, 1'b0};
    tbl[6]  = '{4'h4, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{4'h4, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};
    tbl[8]  = '{4'h5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{4'h5, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    tbl[10] = '{4'h6, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{4'h6, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
    tbl[12] = '{4'h7, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
    tbl[13] = '{4'h7, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[14] = '{4'h7, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0};
    tbl[15] = '{4'h0, 8'h33, 8'h00, 8'h33, 1'b0, 1'b0};
    tbl[16] = '{4'h1, 8'h33, 8'h00, 8'h80, 1'b0, 1'b0};
    tbl[17] = '{4'hC, 8'h33, 8'h00, 8'h33, 1'b0, 1'b0};

    rst8 = 1'b1; rst16 = 1'b1; rstp = 1'b1;
    for (int i = 0; i < 16; i++) begin rom8[i] = '0; rom16[i] = '0; end
    for (int i = 0; i < 4; i++) romp[i] = '0;

    // ALU table: op r1,r2 then OUT r1, BZ 9, BC 12 / BC 13 encodes Z,C in the final address
    for (int t = 0; t < 18; t++) begin
      v = tbl[t];
      for (int i = 0; i < 16; i++) rom8[i] = '0;
      rom8[0] = {4'h1, 3'd1, 1'b0, v.a};
      rom8[1] = {4'h1, 3'd2, 1'b0, v.b};
      rom8[2] = {v.op, 3'd1, 3'd2, 6'd0};
      rom8[3] = 16'hF200;
      rom8[4] = 16'h9009;
      rom8[5] = 16'hB00C;
      rom8[9] = 16'hB00D;
      exp_addr = v.c ? (v.z ? 13 : 12) : (v.z ? 10 : 6);
      rst8 = 1'b1; step(1); rst8 = 1'b0;
      step(4);
      check($sformatf("tbl%0d_result", t), res8, v.r);
      check($sformatf("tbl%0d_valid", t), ov8, 1);
      step(1);
      check($sformatf("tbl%0d_valid_drop", t), ov8, 0);
      step(1);
      check($sformatf("tbl%0d_flags_addr", t), addr8, exp_addr);
    end

    // Reset state then LDI/OUT
    rom16[0] = 16'h122A;
    rom16[1] = 16'hF200;
    rst16 = 1'b1; step(2);
    check("rst_addr", addr16, 0);
    check("rst_result", res16, 0);
    check("rst_valid", ov16, 0);
    check("rst_halted", hlt16, 0);
    rst16 = 1'b0;
    step(1);
    check("ldi_addr", addr16, 1);
    check("ldi_valid", ov16, 0);
    step(1);
    check("out_result", res16, 16'h002A);
    check("out_valid", ov16, 1);
    check("out_addr", addr16, 2);
    step(1);
    check("out_valid_width", ov16, 0);
    check("out_result_hold", res16, 16'h002A);

    // SUB borrow, BNZ taken, BZ not taken, BC taken
    for (int i = 0; i < 16; i++) rom16[i] = '0;
    rom16[0] = 16'h1203;
    rom16[1] = 16'h1405;
    rom16[2] = 16'h3280;
    rom16[3] = 16'hF200;
    rom16[4] = 16'hA008;
    rom16[8] = 16'h9000;
    rom16[9] = 16'hB00C;
    rst16 = 1'b1; step(1); rst16 = 1'b0;
    step(4);
    check("sub_result", res16, 16'hFFFE);
    step(1);
    check("sub_bnz", addr16, 8);
    step(1);
    check("sub_bz", addr16, 9);
    step(1);
    check("sub_bc", addr16, 12);

    // HALT at address 3
    for (int i = 0; i < 16; i++) rom16[i] = '0;
    rom16[3] = 16'hE000;
    rom16[4] = 16'h1211;
    rom16[5] = 16'hF200;
    rst16 = 1'b1; step(1); rst16 = 1'b0;
    step(4);
    check("halt_addr", addr16, HALT_EN ? 3 : 4);
    check("halt_flag", hlt16, HALT_EN ? 1 : 0);
    step(10);
    check("halt_addr_late", addr16, HALT_EN ? 3 : 14);
    check("halt_result_late", res16, HALT_EN ? 0 : 16'h0011);
    check("halt_flag_late", hlt16, HALT_EN ? 1 : 0);
    rst16 = 1'b1; step(1);
    check("halt_rst_addr", addr16, 0);
    check("halt_rst_flag", hlt16, 0);
    check("halt_rst_result", res16, 0);
    rst16 = 1'b0;

    // Prescaler TICK_DIV=4
    romp[0] = 16'h105A; romp[1] = 16'hF000; romp[2] = '0; romp[3] = '0;
    rstp = 1'b1; step(1); rstp = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("presc_addr_clk%0d", k), addrp, (k / 4) % 4);
      check($sformatf("presc_valid_clk%0d", k), ovp, (k == 8) ? 1 : 0);
    end
    check("presc_result", resp, 16'h005A);

    // Wrap 3 -> 0 with ADDR_W=2
    for (int i = 0; i < 4; i++) romp[i] = '0;
    rstp = 1'b1; step(1); rstp = 1'b0;
    step(12);
    check("wrap_addr3", addrp, 3);
    step(4);
    check("wrap_addr0", addrp, 0);

    // JMP to self loops forever
    romp[2] = 16'h8002;
    rstp = 1'b1; step(1); rstp = 1'b0;
    step(8);
    check("loop_enter", addrp, 2);
    for (int i = 0; i < 10; i++) begin
      step(4);
      check($sformatf("loop_hold%0d", i), addrp, 2);
    end

    // Random programs against the model, with a mid-program reset on odd programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        w = 16'($urandom);
        w[15:12] = 4'($urandom_range(0, 15));
        rom16[i] = w;
      end
      rst16 = 1'b1;
      model_reset();
      step(1);
      rst16 = 1'b0;
      check($sformatf("rnd%0d_rst_addr", p), addr16, m_pc);
      check($sformatf("rnd%0d_rst_result", p), res16, m_result);
      for (int k = 0; k < 40; k++) begin
        if ((p % 2 == 1) && (k == 25)) begin
          rst16 = 1'b1;
          model_reset();
          step(1);
          rst16 = 1'b0;
        end else begin
          model_step(rom16[m_pc]);
          step(1);
        end
        check($sformatf("rnd%0d_%0d_addr", p, k), addr16, m_pc);
        check($sformatf("rnd%0d_%0d_result", p, k), res16, m_result);
        check($sformatf("rnd%0d_%0d_valid", p, k), ov16, m_ov);
        check($sformatf("rnd%0d_%0d_halted", p, k), hlt16, m_halted);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
